// File: rtl/instr_decode_ctrl_pkg.sv
// Shared constants for the instruction decode controller: opcodes, ALU
// operation encodings, FSM state encodings and instruction field positions.
package instr_decode_ctrl_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam int OPC_LSB  = 24;
  localparam int DEST_LSB = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;
  localparam int IMM_LSB  = 0;

endpackage

// File: rtl/instr_decode_ctrl_decoder.sv
// Combinational opcode decoder: opcode -> ALU operation, operand-2 mux
// selects and a legal flag. Unknown opcodes decode to all-zero controls.
module instr_decoder
  import instr_decode_ctrl_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic [2:0] o_aluop,
  output logic       o_imm_sel,
  output logic       o_neg_sel,
  output logic       o_legal
);

  // opcode lookup; sub reuses the adder with a negated second operand
  always_comb begin
    o_aluop   = ALU_FWD;
    o_imm_sel = 1'b0;
    o_neg_sel = 1'b0;
    o_legal   = 1'b1;
    case (i_opcode)
      OP_LOADI: o_imm_sel = 1'b1;
      OP_MOV:   o_aluop   = ALU_FWD;
      OP_ADD:   o_aluop   = ALU_ADD;
      OP_SUB: begin
        o_aluop   = ALU_ADD;
        o_neg_sel = 1'b1;
      end
      OP_AND:   o_aluop   = ALU_AND;
      OP_OR:    o_aluop   = ALU_OR;
      default:  o_legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_decode_ctrl.sv
// Instruction decode controller: accepts one instruction per handshake,
// drives register-file addresses and datapath mux controls, and sequences
// read / execute / write-back.
//
// state    | meaning
// S_IDLE   | ready for a new instruction, outputs hold last values
// S_DECODE | fields latched, controls valid; illegal opcodes abort here
// S_EXEC   | reg file read settles, ALU computes
// S_WB     | write strobe high, reg file writes on the closing edge
module instr_decode_ctrl
  import instr_decode_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  output logic [ADDR_W-1:0] READREG1,
  output logic [ADDR_W-1:0] READREG2,
  output logic [ADDR_W-1:0] WRITEREG,
  output logic              WRITEENABLE,
  output logic [2:0]        ALUOP,
  output logic [DATA_W-1:0] IMMEDIATE,
  output logic              IMM_SEL,
  output logic              NEG_SEL,
  output logic              BUSY,
  output logic              ILLEGAL,
  output logic [CNT_W-1:0]  RETIRED
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_dest;
  logic [ADDR_W-1:0] r_src1;
  logic [ADDR_W-1:0] r_src2;
  logic [DATA_W-1:0] r_imm;
  logic [2:0]        r_aluop;
  logic              r_imm_sel;
  logic              r_neg_sel;
  logic              r_legal;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_retired;

  logic [2:0]        w_aluop;
  logic              w_imm_sel;
  logic              w_neg_sel;
  logic              w_legal;
  logic              w_accept;
  logic              w_unused;

  // decode straight off the input so the controls are registered with the fields
  instr_decoder u_decoder (
    .i_opcode  (INSTRUCTION[OPC_LSB +: 8]),
    .o_aluop   (w_aluop),
    .o_imm_sel (w_imm_sel),
    .o_neg_sel (w_neg_sel),
    .o_legal   (w_legal)
  );

  assign w_accept = INSTR_VALID && (r_state == S_IDLE);
  assign w_unused = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

  // sequencing FSM; illegal opcodes return to idle without exec/write-back
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   if (w_accept) r_state <= S_DECODE;
        S_DECODE: begin
          if (r_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_EXEC:   r_state <= S_WB;
        S_WB:     r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // instruction field and decoded-control latch, loaded only on accept
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_dest    <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_imm     <= '0;
      r_aluop   <= ALU_FWD;
      r_imm_sel <= 1'b0;
      r_neg_sel <= 1'b0;
      r_legal   <= 1'b0;
    end else if (w_accept) begin
      r_dest    <= INSTRUCTION[DEST_LSB +: ADDR_W];
      r_src1    <= INSTRUCTION[SRC1_LSB +: ADDR_W];
      r_src2    <= INSTRUCTION[SRC2_LSB +: ADDR_W];
      r_imm     <= INSTRUCTION[IMM_LSB +: DATA_W];
      r_aluop   <= w_aluop;
      r_imm_sel <= w_imm_sel;
      r_neg_sel <= w_neg_sel;
      r_legal   <= w_legal;
    end
  end

  // retired counter, bumped on the edge that performs the write; wraps silently
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_retired <= '0;
    end else if (r_state == S_WB) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // write strobe is decoded from state so reset drops it immediately
  assign WRITEENABLE = (r_state == S_WB);
  assign INSTR_READY = (r_state == S_IDLE) && RESET;
  assign BUSY        = (r_state != S_IDLE);
  assign READREG1    = r_src1;
  assign READREG2    = r_src2;
  assign WRITEREG    = r_dest;
  assign ALUOP       = r_aluop;
  assign IMMEDIATE   = r_imm;
  assign IMM_SEL     = r_imm_sel;
  assign NEG_SEL     = r_neg_sel;
  assign ILLEGAL     = r_illegal;
  assign RETIRED     = r_retired;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Bench for instr_decode_ctrl: table of instructions with expected decode,
// a write-back scoreboard, and hand sequences for reset and streaming.
module tb_instr_decode_ctrl;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  aluop;
    logic        imm_sel;
    logic        neg_sel;
    logic        legal;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } sb_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic        INSTR_VALID = 1'b0;
  logic        INSTR_READY;
  logic [2:0]  READREG1, READREG2, WRITEREG;
  logic        WRITEENABLE;
  logic [2:0]  ALUOP;
  logic [7:0]  IMMEDIATE;
  logic        IMM_SEL, NEG_SEL, BUSY, ILLEGAL;
  logic [15:0] RETIRED;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int we_seen = 0;
  sb_t sb_q[$];

  instr_decode_ctrl dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .READREG1(READREG1), .READREG2(READREG2),
    .WRITEREG(WRITEREG), .WRITEENABLE(WRITEENABLE), .ALUOP(ALUOP),
    .IMMEDIATE(IMMEDIATE), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL), .BUSY(BUSY),
    .ILLEGAL(ILLEGAL), .RETIRED(RETIRED)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [2:0] aluop,
                              input logic imm_sel, input logic neg_sel, input logic legal);
    vec_t v;
    v.instr = instr; v.aluop = aluop; v.imm_sel = imm_sel; v.neg_sel = neg_sel; v.legal = legal;
    return v;
  endfunction

  // write-back monitor: every strobe must match the oldest pending instruction
  always @(negedge CLK) begin
    if (RESET && WRITEENABLE) begin
      we_seen++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL we_unexpected: WRITEENABLE=1 WRITEREG=%0d, expected no write", WRITEREG);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("wb_writereg", WRITEREG, e.v.instr[18:16]);
        check("wb_readreg1", READREG1, e.v.instr[10:8]);
        check("wb_readreg2", READREG2, e.v.instr[2:0]);
        check("wb_aluop", ALUOP, e.v.aluop);
        check("wb_imm_sel", IMM_SEL, e.v.imm_sel);
        check("wb_neg_sel", NEG_SEL, e.v.neg_sel);
        if (e.v.imm_sel) check("wb_immediate", IMMEDIATE, e.v.instr[7:0]);
        check("wb_latency", cyc - e.acc, 3);
        check("wb_ready_low", INSTR_READY, 0);
      end
    end
  end

  // present one instruction, wait (bounded) for acceptance, return at the DECODE negedge
  task automatic issue(input vec_t v);
    int t;
    sb_t e;
    @(negedge CLK);
    INSTR_VALID = 1'b1;
    INSTRUCTION = v.instr;
    t = 0;
    while (!INSTR_READY && t < 20) begin
      @(negedge CLK);
      t++;
    end
    if (!INSTR_READY) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: INSTR_READY=0 after %0d cycles, expected 1", t);
    end
    if (v.legal) begin
      e.v = v;
      e.acc = cyc;
      sb_q.push_back(e);
    end
    @(negedge CLK);
    INSTR_VALID = 1'b0;
  endtask

  vec_t tbl[9];
  vec_t strm[5];
  int   exp_retired;
  logic exp_illegal;

  initial begin
    tbl[0] = mk(32'h0004000C, 3'b000, 1'b1, 1'b0, 1'b1);
    tbl[1] = mk(32'h03020103, 3'b001, 1'b0, 1'b1, 1'b1);
    tbl[2] = mk(32'h01070500, 3'b000, 1'b0, 1'b0, 1'b1);
    tbl[3] = mk(32'h02010203, 3'b001, 1'b0, 1'b0, 1'b1);
    tbl[4] = mk(32'h04060104, 3'b010, 1'b0, 1'b0, 1'b1);
    tbl[5] = mk(32'h05030706, 3'b011, 1'b0, 1'b0, 1'b1);
    tbl[6] = mk(32'h07010203, 3'b000, 1'b0, 1'b0, 1'b0);
    tbl[7] = mk(32'h02050607, 3'b001, 1'b0, 1'b0, 1'b1);
    tbl[8] = mk(32'hFF020304, 3'b000, 1'b0, 1'b0, 1'b0);

    strm[0] = mk(32'h05010203, 3'b011, 1'b0, 1'b0, 1'b1);
    strm[1] = mk(32'h04020304, 3'b010, 1'b0, 1'b0, 1'b1);
    strm[2] = mk(32'h02030405, 3'b001, 1'b0, 1'b0, 1'b1);
    strm[3] = mk(32'h01040506, 3'b000, 1'b0, 1'b0, 1'b1);
    strm[4] = mk(32'h000500A5, 3'b000, 1'b1, 1'b0, 1'b1);

    // reset held for 3 cycles
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", INSTR_READY, 0);
    check("rst_we", WRITEENABLE, 0);
    check("rst_busy", BUSY, 0);
    RESET = 1'b1;
    @(negedge CLK);
    check("post_rst_ready", INSTR_READY, 1);
    check("post_rst_addrs", {READREG1, READREG2, WRITEREG}, 0);
    check("post_rst_ctrl", {WRITEENABLE, ALUOP, IMM_SEL, NEG_SEL, BUSY, ILLEGAL}, 0);
    check("post_rst_imm", IMMEDIATE, 0);
    check("post_rst_retired", RETIRED, 0);

    // table of single instructions
    exp_retired = 0;
    exp_illegal = 1'b0;
    for (int i = 0; i < 9; i++) begin
      int lo;
      issue(tbl[i]);
      check("dec_busy", BUSY, 1);
      if (tbl[i].legal) begin
        check("dec_readreg1", READREG1, tbl[i].instr[10:8]);
        check("dec_readreg2", READREG2, tbl[i].instr[2:0]);
        check("dec_aluop", ALUOP, tbl[i].aluop);
        check("dec_imm_sel", IMM_SEL, tbl[i].imm_sel);
        check("dec_neg_sel", NEG_SEL, tbl[i].neg_sel);
        check("dec_we", WRITEENABLE, 0);
        exp_retired++;
      end else begin
        exp_illegal = 1'b1;
      end
      lo = 0;
      while (!INSTR_READY && lo < 10) begin
        lo++;
        @(negedge CLK);
      end
      check("ready_low_cycles", lo, tbl[i].legal ? 3 : 1);
      check("tbl_retired", RETIRED, exp_retired);
      check("tbl_illegal", ILLEGAL, exp_illegal);
      check("tbl_busy_idle", BUSY, 0);
    end

    // reset in the middle of EXEC of an or
    begin
      int we_before;
      issue(mk(32'h05010203, 3'b011, 1'b0, 1'b0, 1'b1));
      @(negedge CLK);
      we_before = we_seen;
      RESET = 1'b0;
      #1;
      check("midrst_we", WRITEENABLE, 0);
      check("midrst_busy", BUSY, 0);
      check("midrst_ready", INSTR_READY, 0);
      sb_q.delete();
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      check("midrst_idle", INSTR_READY, 1);
      check("midrst_retired", RETIRED, 0);
      check("midrst_illegal", ILLEGAL, 0);
      repeat (4) @(negedge CLK);
      check("midrst_no_we", we_seen, we_before);
    end

    // back-to-back stream with the counter preset to all ones
    begin
      int acc[5];
      int idx;
      int t;
      int we_before;
      @(negedge CLK);
      force dut.r_retired = 16'hFFFF;
      @(negedge CLK);
      release dut.r_retired;
      @(negedge CLK);
      check("preset_retired", RETIRED, 16'hFFFF);
      we_before = we_seen;
      idx = 0;
      t = 0;
      INSTR_VALID = 1'b1;
      INSTRUCTION = strm[0].instr;
      while (idx < 5 && t < 100) begin
        if (INSTR_READY) begin
          sb_t e;
          e.v = strm[idx];
          e.acc = cyc;
          sb_q.push_back(e);
          acc[idx] = cyc;
          idx++;
        end
        @(negedge CLK);
        t++;
        if (idx < 5) INSTRUCTION = strm[idx].instr;
      end
      INSTR_VALID = 1'b0;
      check("stream_accepts", idx, 5);
      for (int k = 1; k < 5; k++) check("stream_spacing", acc[k] - acc[k-1], 4);
      t = 0;
      while ((sb_q.size() != 0 || !INSTR_READY) && t < 50) begin
        @(negedge CLK);
        t++;
      end
      check("stream_we_pulses", we_seen - we_before, 5);
      check("stream_retired_wrap", RETIRED, 16'h0004);
      check("stream_illegal", ILLEGAL, 0);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
